// File: rtl/fuzz_chk_pkg.sv
// Shared types and helpers for the fuzz identity checker: FSM encoding,
// default MISR constants and the Y -> signature fold function.
package fuzz_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int unsigned FOLD_Y_MAX   = 1024;
    localparam int unsigned FOLD_SIG_MAX = 64;

    localparam logic [31:0]             DEF_SIG_POLY = 32'h04C11DB7;
    localparam logic [FOLD_SIG_MAX-1:0] DEF_SIG_SEED = '1;

    // XOR of y split into sig_width chunks (LSB chunk first, last chunk
    // zero-padded); bit i of y lands on bit (i mod sig_width) of the result.
    function automatic logic [FOLD_SIG_MAX-1:0] fold_to_sig(
        input logic [FOLD_Y_MAX-1:0] y,
        input int unsigned           y_width,
        input int unsigned           sig_width
    );
        logic [FOLD_SIG_MAX-1:0] acc;
        logic [5:0]              pos;
        acc = '0;
        for (int unsigned i = 0; i < FOLD_Y_MAX; i++) begin
            if (i < y_width) begin
                pos      = 6'(i % sig_width);
                acc[pos] = acc[pos] ^ y[i];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/fuzz_identity_checker_if.sv
// Bundle of the run-control, sample and result signals of the identity checker.
interface fuzz_identity_checker_if #(
    parameter int unsigned Y_WIDTH   = 242,
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned SIG_WIDTH = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                        start;
    logic                        abort;
    logic [CNT_WIDTH-1:0]        run_len;
    logic [SIG_WIDTH-1:0]        exp_sig;
    logic                        y_valid;
    logic [NUM_CH*Y_WIDTH-1:0]   y_in;
    logic                        busy;
    logic                        done;
    logic [SIG_WIDTH-1:0]        signature;
    logic                        sig_match;
    logic [NUM_CH-1:0]           mis_mask;
    logic [CNT_WIDTH-1:0]        first_mis_idx;
    logic                        first_mis_vld;
    logic [CNT_WIDTH-1:0]        sample_cnt;

    modport master (
        output start, abort, run_len, exp_sig, y_valid, y_in,
        input  busy, done, signature, sig_match, mis_mask,
               first_mis_idx, first_mis_vld, sample_cnt
    );

    modport slave (
        input  start, abort, run_len, exp_sig, y_valid, y_in,
        output busy, done, signature, sig_match, mis_mask,
               first_mis_idx, first_mis_vld, sample_cnt
    );

endinterface

// File: rtl/fuzz_misr.sv
// Multiple-input signature register: shift left, feed back SIG_POLY on the
// outgoing MSB, XOR in the data word.
module fuzz_misr
    import fuzz_chk_pkg::*;
#(
    parameter int unsigned           SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0]  SIG_POLY  = SIG_WIDTH'(DEF_SIG_POLY)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [SIG_WIDTH-1:0] seed,
    input  logic                 en,
    input  logic [SIG_WIDTH-1:0] data,
    output logic [SIG_WIDTH-1:0] sig
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig <= seed;
        end else if (load) begin
            sig <= seed;
        end else if (en) begin
            sig <= {sig[SIG_WIDTH-2:0], 1'b0}
                 ^ (sig[SIG_WIDTH-1] ? SIG_POLY : '0)
                 ^ data;
        end
    end

endmodule

// File: rtl/fuzz_identity_checker.sv
// Lockstep comparator of NUM_CH design copies against channel 0, with sticky
// divergence tracking and a channel-0 MISR signature over a run of samples.
module fuzz_identity_checker
    import fuzz_chk_pkg::*;
#(
    parameter int unsigned           Y_WIDTH   = 242,
    parameter int unsigned           NUM_CH    = 2,
    parameter int unsigned           SIG_WIDTH = 32,
    parameter logic [SIG_WIDTH-1:0]  SIG_POLY  = SIG_WIDTH'(DEF_SIG_POLY),
    parameter logic [SIG_WIDTH-1:0]  SIG_SEED  = SIG_WIDTH'(DEF_SIG_SEED),
    parameter int unsigned           CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fuzz_identity_checker_if.slave  bus
);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   run_len_q;
    logic [SIG_WIDTH-1:0]   exp_sig_q;
    logic [CNT_WIDTH-1:0]   sample_cnt;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [CNT_WIDTH-1:0]   first_mis_idx;
    logic                   first_mis_vld;
    logic [NUM_CH-1:0]      mis_mask;
    logic [NUM_CH-1:0]      neq;
    logic                   sig_match_q;
    logic [SIG_WIDTH-1:0]   sig;
    logic [SIG_WIDTH-1:0]   fold;
    logic [Y_WIDTH-1:0]     y0;
    logic                   misr_load;
    logic                   misr_en;

    assign y0        = bus.y_in[Y_WIDTH-1:0];
    assign cnt_inc   = sample_cnt + CNT_WIDTH'(1);
    assign misr_load = (state == ST_IDLE) && bus.start;
    // An abort wins over a coincident sample, so that sample is not folded in.
    assign misr_en   = (state == ST_RUN) && bus.y_valid && !bus.abort;

    always_comb begin
        fold = SIG_WIDTH'(fold_to_sig(FOLD_Y_MAX'(y0), Y_WIDTH, SIG_WIDTH));
    end

    always_comb begin
        neq = '0;
        for (int unsigned c = 1; c < NUM_CH; c++) begin
            neq[c] = (bus.y_in[c*Y_WIDTH +: Y_WIDTH] != y0);
        end
    end

    fuzz_misr #(
        .SIG_WIDTH (SIG_WIDTH),
        .SIG_POLY  (SIG_POLY)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (misr_load),
        .seed  (SIG_SEED),
        .en    (misr_en),
        .data  (fold),
        .sig   (sig)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            run_len_q     <= '0;
            exp_sig_q     <= '0;
            sample_cnt    <= '0;
            first_mis_idx <= '0;
            first_mis_vld <= 1'b0;
            mis_mask      <= '0;
            sig_match_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        run_len_q     <= bus.run_len;
                        exp_sig_q     <= bus.exp_sig;
                        sample_cnt    <= '0;
                        first_mis_idx <= '0;
                        first_mis_vld <= 1'b0;
                        mis_mask      <= '0;
                        sig_match_q   <= 1'b0;
                        state         <= (bus.run_len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state <= ST_IDLE;
                    end else if (bus.y_valid) begin
                        mis_mask   <= mis_mask | neq;
                        sample_cnt <= cnt_inc;
                        if ((|neq) && !first_mis_vld) begin
                            first_mis_idx <= sample_cnt;
                            first_mis_vld <= 1'b1;
                        end
                        if (cnt_inc == run_len_q) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    sig_match_q <= (sig == exp_sig_q);
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The signature is final in DONE, so the match is live there and held after.
    assign bus.busy          = (state == ST_RUN);
    assign bus.done          = (state == ST_DONE);
    assign bus.sig_match     = (state == ST_DONE) ? (sig == exp_sig_q) : sig_match_q;
    assign bus.signature     = sig;
    assign bus.mis_mask      = mis_mask;
    assign bus.first_mis_idx = first_mis_idx;
    assign bus.first_mis_vld = first_mis_vld;
    assign bus.sample_cnt    = sample_cnt;

endmodule

// File: tb/tb_fuzz_identity_checker.sv
// Scoreboard bench for fuzz_identity_checker: a small 3-channel 8-bit
// instance and a default-parameter instance, checked against a software model.
module tb_fuzz_identity_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fuzz_identity_checker_if #(.Y_WIDTH(8),   .NUM_CH(3), .SIG_WIDTH(8),  .CNT_WIDTH(16)) bs ();
    fuzz_identity_checker_if #(.Y_WIDTH(242), .NUM_CH(2), .SIG_WIDTH(32), .CNT_WIDTH(16)) bd ();

    fuzz_identity_checker #(
        .Y_WIDTH(8), .NUM_CH(3), .SIG_WIDTH(8), .SIG_POLY(8'h1D),
        .SIG_SEED(8'hFF), .CNT_WIDTH(16)
    ) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs));

    fuzz_identity_checker #(
        .Y_WIDTH(242), .NUM_CH(2), .SIG_WIDTH(32), .SIG_POLY(32'h04C11DB7),
        .SIG_SEED(32'hFFFF_FFFF), .CNT_WIDTH(16)
    ) dut_d (.clk(clk), .rst_n(rst_n), .bus(bd));

    typedef struct {
        logic [63:0] sig, mask, idx, cnt, len, exp;
        logic        vld;
    } model_t;

    typedef struct {
        logic [63:0] sig, mask, idx, cnt;
        logic        vld, match;
    } exp_t;

    int     total = 0;
    int     bad   = 0;
    exp_t   q_s[$];
    exp_t   q_d[$];
    exp_t   es, ed;
    model_t ms, md;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_fold(input logic [511:0] y, input int yw, input int sw);
        logic [63:0]  m, acc;
        logic [511:0] yy;
        m   = (64'd1 << sw) - 64'd1;
        yy  = y & ((512'd1 << yw) - 512'd1);
        acc = '0;
        for (int k = 0; k * sw < yw; k++) acc = acc ^ (64'(yy >> (k * sw)) & m);
        return acc;
    endfunction

    function automatic logic [63:0] model_step(input logic [63:0] s, input logic [63:0] f,
                                               input int sw, input logic [63:0] poly);
        logic [63:0] m;
        m = (64'd1 << sw) - 64'd1;
        return (((s << 1) ^ (s[sw-1] ? poly : 64'd0)) ^ f) & m;
    endfunction

    function automatic void m_sample(inout model_t m, input logic [511:0] y, input int yw,
                                     input int nch, input int sw, input logic [63:0] poly);
        logic [511:0] ym, c0, cc;
        logic any;
        ym  = (512'd1 << yw) - 512'd1;
        c0  = y & ym;
        any = 1'b0;
        for (int c = 1; c < nch; c++) begin
            cc = (y >> (c * yw)) & ym;
            if (cc != c0) begin
                m.mask[c] = 1'b1;
                any       = 1'b1;
            end
        end
        if (any && !m.vld) begin
            m.idx = m.cnt;
            m.vld = 1'b1;
        end
        m.cnt = m.cnt + 64'd1;
        m.sig = model_step(m.sig, model_fold(c0, yw, sw), sw, poly);
    endfunction

    function automatic exp_t to_exp(input model_t m);
        exp_t e;
        e.sig = m.sig; e.mask = m.mask; e.idx = m.idx; e.cnt = m.cnt;
        e.vld = m.vld; e.match = (m.sig == m.exp);
        return e;
    endfunction

    function automatic model_t new_model(input int len, input logic [63:0] e, input logic [63:0] seed);
        model_t m;
        m.sig = seed; m.mask = '0; m.idx = '0; m.cnt = '0;
        m.len = 64'(len); m.exp = e; m.vld = 1'b0;
        return m;
    endfunction

    function automatic logic [241:0] rand_y();
        logic [255:0] t;
        for (int j = 0; j < 8; j++) t[j*32 +: 32] = $urandom;
        return 242'(t);
    endfunction

    task automatic sync();
        @(posedge clk); #1;
    endtask

    // Small instance drivers (entered and left at posedge+1)
    task automatic s_start(input int len, input logic [7:0] e);
        bs.start = 1'b1; bs.run_len = 16'(len); bs.exp_sig = e;
        sync();
        bs.start = 1'b0;
        ms = new_model(len, 64'(e), 64'hFF);
        if (len == 0) q_s.push_back(to_exp(ms));
    endtask

    task automatic s_sample(input logic [23:0] y);
        bs.y_valid = 1'b1; bs.y_in = y;
        sync();
        bs.y_valid = 1'b0;
        m_sample(ms, 512'(y), 8, 3, 8, 64'h1D);
        if (ms.cnt == ms.len) q_s.push_back(to_exp(ms));
    endtask

    task automatic d_start(input int len, input logic [31:0] e);
        bd.start = 1'b1; bd.run_len = 16'(len); bd.exp_sig = e;
        sync();
        bd.start = 1'b0;
        md = new_model(len, 64'(e), 64'hFFFF_FFFF);
        if (len == 0) q_d.push_back(to_exp(md));
    endtask

    task automatic d_sample(input logic [483:0] y, input logic ab);
        bd.y_valid = 1'b1; bd.y_in = y; bd.abort = ab;
        sync();
        bd.y_valid = 1'b0; bd.abort = 1'b0;
        if (!ab) begin
            m_sample(md, 512'(y), 242, 2, 32, 64'h04C1_1DB7);
            if (md.cnt == md.len) q_d.push_back(to_exp(md));
        end
    endtask

    task automatic wait_s(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (q_s.size() == 0) break;
            sync();
        end
        check(tag, 64'(q_s.size()), 64'd0);
        q_s.delete();
    endtask

    task automatic wait_d(input string tag);
        for (int i = 0; i < 50; i++) begin
            if (q_d.size() == 0) break;
            sync();
        end
        check(tag, 64'(q_d.size()), 64'd0);
        q_d.delete();
    endtask

    // Scoreboard: every done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (bs.done) begin
            check("s_done_expected", 64'(q_s.size() != 0), 64'd1);
            if (q_s.size() != 0) begin
                es = q_s.pop_front();
                check("s_sig",   64'(bs.signature),     es.sig);
                check("s_mask",  64'(bs.mis_mask),      es.mask);
                check("s_vld",   64'(bs.first_mis_vld), 64'(es.vld));
                if (es.vld) check("s_idx", 64'(bs.first_mis_idx), es.idx);
                check("s_cnt",   64'(bs.sample_cnt),    es.cnt);
                check("s_match", 64'(bs.sig_match),     64'(es.match));
            end
        end
        if (bd.done) begin
            check("d_done_expected", 64'(q_d.size() != 0), 64'd1);
            if (q_d.size() != 0) begin
                ed = q_d.pop_front();
                check("d_sig",   64'(bd.signature),     ed.sig);
                check("d_mask",  64'(bd.mis_mask),      ed.mask);
                check("d_vld",   64'(bd.first_mis_vld), 64'(ed.vld));
                if (ed.vld) check("d_idx", 64'(bd.first_mis_idx), ed.idx);
                check("d_cnt",   64'(bd.sample_cnt),    ed.cnt);
                check("d_match", 64'(bd.sig_match),     64'(ed.match));
            end
        end
    end

    task automatic check_d_reset(input string tag);
        check({tag, "_busy"},  64'(bd.busy),          64'd0);
        check({tag, "_done"},  64'(bd.done),          64'd0);
        check({tag, "_match"}, 64'(bd.sig_match),     64'd0);
        check({tag, "_vld"},   64'(bd.first_mis_vld), 64'd0);
        check({tag, "_sig"},   64'(bd.signature),     64'hFFFF_FFFF);
        check({tag, "_mask"},  64'(bd.mis_mask),      64'd0);
        check({tag, "_idx"},   64'(bd.first_mis_idx), 64'd0);
        check({tag, "_cnt"},   64'(bd.sample_cnt),    64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0]  s3 [8];
        logic [241:0] yarr [1000];
        logic [241:0] ya, yb;
        logic [7:0]   v;
        model_t       tm;

        bs.start = 0; bs.abort = 0; bs.run_len = '0; bs.exp_sig = '0; bs.y_valid = 0; bs.y_in = '0;
        bd.start = 0; bd.abort = 0; bd.run_len = '0; bd.exp_sig = '0; bd.y_valid = 0; bd.y_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_sig",  64'(bs.signature), 64'hFF);
        check("rst_s_busy", 64'(bs.busy),      64'd0);
        check("rst_s_mask", 64'(bs.mis_mask),  64'd0);
        check_d_reset("rst_d");
        sync();
        rst_n = 1'b1;
        sync();

        // 1: single zero sample -> E3
        s_start(1, 8'hE3);
        @(negedge clk);
        check("t1_busy",     64'(bs.busy), 64'd1);
        check("t1_no_done",  64'(bs.done), 64'd0);
        sync();
        s_sample(24'h000000);
        @(negedge clk);
        check("t1_done",  64'(bs.done),      64'd1);
        check("t1_sig",   64'(bs.signature), 64'hE3);
        check("t1_match", 64'(bs.sig_match), 64'd1);
        check("t1_mask",  64'(bs.mis_mask),  64'd0);
        sync();
        wait_s("t1_drain");
        check("t1_match_hold", 64'(bs.sig_match), 64'd1);

        // 2: zero-length runs
        s_start(0, 8'hFF);
        @(negedge clk);
        check("t2_done",  64'(bs.done),       64'd1);
        check("t2_sig",   64'(bs.signature),  64'hFF);
        check("t2_cnt",   64'(bs.sample_cnt), 64'd0);
        check("t2_match", 64'(bs.sig_match),  64'd1);
        sync();
        wait_s("t2_drain");
        s_start(0, 8'h12);
        sync();
        wait_s("t2b_drain");

        // 3: three channels, channel 2 diverges on sample 5, gap mid-run
        for (int i = 0; i < 8; i++) begin
            v = 8'($urandom);
            s3[i] = {(i == 5) ? (v ^ 8'h5A) : v, v, v};
        end
        tm = new_model(8, 0, 64'hFF);
        for (int i = 0; i < 8; i++) m_sample(tm, 512'(s3[i]), 8, 3, 8, 64'h1D);
        s_start(8, 8'(tm.sig));
        for (int i = 0; i < 4; i++) s_sample(s3[i]);
        bs.y_in = 24'hA53C00;
        sync();
        sync();
        @(negedge clk);
        check("t3_gap_cnt",  64'(bs.sample_cnt), 64'd4);
        check("t3_gap_mask", 64'(bs.mis_mask),   64'd0);
        check("t3_gap_busy", 64'(bs.busy),       64'd1);
        sync();
        for (int i = 4; i < 8; i++) s_sample(s3[i]);
        @(negedge clk);
        check("t3_done", 64'(bs.done),          64'd1);
        check("t3_mask", 64'(bs.mis_mask),      64'b100);
        check("t3_idx",  64'(bs.first_mis_idx), 64'd5);
        check("t3_vld",  64'(bs.first_mis_vld), 64'd1);
        check("t3_cnt",  64'(bs.sample_cnt),    64'd8);
        sync();
        wait_s("t3_drain");

        // 4: abort coincident with the final sample, then immediate restart
        d_start(3, 32'h0);
        for (int i = 0; i < 2; i++) begin
            ya = rand_y();
            d_sample({ya, ya}, 1'b0);
        end
        ya = rand_y();
        d_sample({ya, ya}, 1'b1);
        @(negedge clk);
        check("t4_abort_busy", 64'(bd.busy), 64'd0);
        check("t4_abort_done", 64'(bd.done), 64'd0);
        ya = rand_y();
        tm = new_model(1, 0, 64'hFFFF_FFFF);
        m_sample(tm, 512'({ya, ya}), 242, 2, 32, 64'h04C1_1DB7);
        d_start(1, 32'(tm.sig));
        @(negedge clk);
        check("t4_restart_busy", 64'(bd.busy), 64'd1);
        sync();
        d_sample({ya, ya}, 1'b0);
        wait_d("t4_drain");

        // 5a: start during RUN must not recapture run_len
        d_start(4, 32'h0);
        ya = rand_y();
        d_sample({ya, ya}, 1'b0);
        bd.start = 1'b1; bd.run_len = 16'd2;
        ya = rand_y();
        d_sample({ya, ya}, 1'b0);
        bd.start = 1'b0;
        @(negedge clk);
        check("t5_start_ignored_cnt", 64'(bd.sample_cnt), 64'd2);
        sync();
        for (int i = 0; i < 2; i++) begin
            ya = rand_y();
            d_sample({ya, ya}, 1'b0);
        end
        wait_d("t5_drain");

        // 5b: one-cycle reset mid-run discards everything
        d_start(5, 32'h0);
        ya = rand_y();
        yb = ya ^ 242'd1;
        d_sample({yb, ya}, 1'b0);
        d_sample({ya, ya}, 1'b0);
        @(negedge clk);
        check("t5_pre_mask", 64'(bd.mis_mask), 64'b10);
        rst_n = 1'b0;
        sync();
        rst_n = 1'b1;
        @(negedge clk);
        check_d_reset("t5_rst");
        repeat (5) sync();
        check("t5_still_idle", 64'(bd.busy), 64'd0);

        // 6: long random identical-channel run against the software MISR
        for (int i = 0; i < 1000; i++) yarr[i] = rand_y();
        tm = new_model(1000, 0, 64'hFFFF_FFFF);
        for (int i = 0; i < 1000; i++) m_sample(tm, 512'({yarr[i], yarr[i]}), 242, 2, 32, 64'h04C1_1DB7);
        d_start(1000, 32'(tm.sig));
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(7) == 0) sync();
            d_sample({yarr[i], yarr[i]}, 1'b0);
        end
        @(negedge clk);
        check("t6_done",  64'(bd.done),      64'd1);
        check("t6_match", 64'(bd.sig_match), 64'd1);
        check("t6_mask",  64'(bd.mis_mask),  64'd0);
        sync();
        wait_d("t6_drain");

        repeat (3) sync();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
